// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the UART transmitter device: register offsets,
// CTRL/STATUS bit positions and the transmitter state encoding.
package uart_tx_dev_pkg;

  // Word offsets decoded from Addr[3:2] of the byte address.
  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_DIVISOR = 2'd1;
  localparam logic [1:0] OFF_TXDATA  = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  // CTRL bits.
  localparam int CTRL_TXEN = 0;
  localparam int CTRL_IEN  = 1;

  // STATUS bits.
  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Packs the STATUS word; the count field is five bits wide so that
  // a 16-entry FIFO can report a full count.
  function automatic logic [31:0] pack_status(
    input logic       busy,
    input logic       full,
    input logic       empty,
    input logic       ovf,
    input logic [4:0] cnt
  );
    logic [31:0] s;
    s = '0;
    s[ST_BUSY]  = busy;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_OVF]   = ovf;
    s[ST_CNT_LSB +: ST_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: DEPTH entries of WIDTH bits, head visible on dout.
// Ports: push/din write, pop advances head, count/full/empty status.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push into a full
  // FIFO is still accepted then.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with FIFO and drain interrupt.
// Ports: clk/reset, device bus (Addr, WE, Din, Dout), IRQ, txd.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        txen_q, txen_d;
  logic        ien_q, ien_d;
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;

  tx_state_e   state_q, state_d;
  logic [15:0] divcnt_q, divcnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;

  logic          wr_ctrl, wr_div, wr_data;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          busy;
  logic          unused_bits;

  assign unused_bits = ^{Addr[29:2], Din[31:16]};

  assign wr_ctrl = WE & (Addr[1:0] == OFF_CTRL);
  assign wr_div  = WE & (Addr[1:0] == OFF_DIVISOR);
  assign wr_data = WE & (Addr[1:0] == OFF_TXDATA);

  assign busy = (state_q != TX_IDLE);
  assign IRQ  = ien_q & fifo_empty & ~busy;
  assign txd  = txd_q;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (Din[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register file updates.
  always_comb begin
    txen_d = txen_q;
    ien_d  = ien_q;
    ovf_d  = ovf_q;
    div_d  = div_q;
    if (wr_ctrl) begin
      txen_d = Din[CTRL_TXEN];
      ien_d  = Din[CTRL_IEN];
      ovf_d  = 1'b0;
    end
    if (wr_div) div_d = Din[15:0];
    if (wr_data & fifo_full & ~fifo_pop) ovf_d = 1'b1;
  end

  // Frame sequencer. Every bit ends on the clock where divcnt hits
  // zero; the reload uses the current DIVISOR so a mid-frame write
  // only stretches later bits.
  always_comb begin
    state_d  = state_q;
    divcnt_d = divcnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (txen_q & ~fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          divcnt_d = div_q;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (divcnt_q == 16'd0) begin
          divcnt_d = div_q;
          bitcnt_d = 3'd0;
          state_d  = TX_DATA;
        end else begin
          divcnt_d = divcnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (divcnt_q == 16'd0) begin
          divcnt_d = div_q;
          shift_d  = {1'b0, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          divcnt_d = divcnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (divcnt_q == 16'd0) begin
          if (txen_q & ~fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            divcnt_d = div_q;
            state_d  = TX_START;
          end else begin
            state_d  = TX_IDLE;
          end
        end else begin
          divcnt_d = divcnt_q - 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line lags the
  // state by one clock.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txen_q   <= 1'b0;
      ien_q    <= 1'b0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
      state_q  <= TX_IDLE;
      divcnt_q <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      txen_q   <= txen_d;
      ien_q    <= ien_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      state_q  <= state_d;
      divcnt_q <= divcnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  // Read mux.
  always_comb begin
    Dout = '0;
    unique case (Addr[1:0])
      OFF_CTRL: begin
        Dout[CTRL_TXEN] = txen_q;
        Dout[CTRL_IEN]  = ien_q;
      end
      OFF_DIVISOR: Dout[15:0] = div_q;
      OFF_TXDATA:  Dout = '0;
      OFF_STATUS: begin
        Dout = pack_status(busy, fifo_full, fifo_empty, ovf_q,
                           ST_CNT_W'(fifo_count));
      end
      default: Dout = '0;
    endcase
  end

endmodule

// File: doc/uart_tx_dev.md
Name: uart_tx_dev

Overview:
- Memory-mapped serial transmitter peripheral.
- Sits on the device side of the system bridge as a responder, alongside the timers, using the same device bus: word address, write enable, write data, read data and a level IRQ.
- The CPU writes bytes into a small transmit FIFO; the block serialises them as 8N1 frames, LSB first, on txd.
- Raises IRQ when the transmitter has fully drained.

Parameters:
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, 2..16.
- DIV_RESET, 16'd433, reset value of DIVISOR; clocks per bit = DIVISOR+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Addr  input  30  word address, byte address [31:2]. Only Addr[3:2] is decoded; the bridge performs range selection.
- WE  input  1  register write strobe, asserted by the bridge for this device.
- Din  input  32  write data.
- Dout  output  32  read data; combinational from Addr[3:2] and current state.
- IRQ  output  1  level interrupt request.
- txd  output  1  serial output; idles high.

Behaviour:
- Register map, by Addr[3:2]:
  - 0 CTRL: [0] TXEN, [1] IEN; other bits read 0.
  - 1 DIVISOR: [15:0]; upper bits read 0.
  - 2 TXDATA: write pushes Din[7:0]; read returns 0.
  - 3 STATUS: read-only, writes ignored. [0] BUSY, [1] FULL, [2] EMPTY, [3] OVF (sticky), [8:4] FIFO count.
- Reset values:
  - CTRL=0, DIVISOR=DIV_RESET, FIFO empty, OVF=0, FSM in IDLE.
  - txd=1, IRQ=0.
  - Dout follows the decode, so reading STATUS after reset gives 0x004.
- Writes take effect on the clk edge where WE=1.
- A CTRL write also clears OVF in the same edge.
- TXDATA push rules:
  - The push is accepted if count<FIFO_DEPTH, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and OVF is set.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. The bit counter bitcnt is 0..7 and the clock counter divcnt is 16 bits.
  - IDLE: txd=1. If TXEN=1 and FIFO not empty: pop the head into the shift register, load divcnt=DIVISOR, go to START on the next edge.
  - START: txd=0 for DIVISOR+1 clocks.
  - DATA: txd=shift[0]. Each bit lasts DIVISOR+1 clocks, then shift right. After bit 7, go to STOP.
  - STOP: txd=1 for DIVISOR+1 clocks. Then, if TXEN=1 and FIFO not empty, pop and go straight to START (back-to-back frames, no idle gap); else go to IDLE.
- Bit timing:
  - divcnt decrements each clock. The bit ends on the clock where divcnt==0, and divcnt reloads from the live DIVISOR.
  - A DIVISOR write mid-frame therefore affects the next bit, not the current one.
  - DIVISOR=0 gives 1 clock per bit.
- BUSY=1 in every state except IDLE.
- Clearing TXEN mid-frame: the current frame completes normally, then no further pop occurs; the FIFO contents are kept.
- IRQ = IEN & EMPTY & ~BUSY. It is combinational from registers and has no glitch-free guarantee beyond that.
- Latency: with TXEN=1 and the FSM in IDLE, a TXDATA write at edge N drives the start bit (txd=0) from edge N+2.
- Full frame length: 10*(DIVISOR+1) clocks.
- Reset asserted mid-frame: txd returns to 1 immediately (asynchronously), the FIFO is flushed, and the partial frame is abandoned.

Decomposition:
- Shared package holds:
  - register offsets (CTRL=2'd0, DIVISOR=2'd1, TXDATA=2'd2, STATUS=2'd3);
  - the CTRL/STATUS bit index constants;
  - the FSM state encoding.
  - The timer device should reuse the same offset style.
- One sub-module: uart_tx_fifo.
  - Parameterised by DEPTH and WIDTH=8.
  - Ports: push, pop, din, dout, count, full, empty; async active-high reset.
  - Same-cycle push and pop when full is legal.

Test Plan:
- Reset, then read all four offsets → CTRL=0, DIVISOR=433, TXDATA=0, STATUS=0x004; txd=1, IRQ=0.
- DIVISOR=3, CTRL=1, write TXDATA=0xA5 → txd pattern 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks. The start bit begins 2 clocks after the write; BUSY is 1 throughout.
- DIVISOR=0, CTRL=1, write 0x01,0x02,0x03 back-to-back → three contiguous 10-clock frames with no idle gap; count reads 2,1,0 as the frames start.
- CTRL=0, write 5 bytes with FIFO_DEPTH=4 → STATUS=0x04A (count 4, OVF, FULL). Then write CTRL=1 → OVF clears and 4 frames are sent.
- CTRL=3, send one byte → IRQ=0 while BUSY, IRQ=1 on the clock after STOP ends. Then write CTRL=1 → IRQ=0.
- Assert reset midway through the DATA bits of a frame → txd=1 asynchronously; after release STATUS=0x004 and no further frame is emitted.
